alu_seq: RTL
============

// Module: alu_seq
// PURPOSE
//   Registered, width-parametrised ALU for the next processor core. Keeps the
//   existing opcode map and flag bus {Z,CY,S,P,OV}, and adds shifts and iterative
//   multiply/divide behind a start/busy/done handshake.
//   Sits between the register-file read ports and the write-back/flag register.
//   The control FSM stalls on busy.
// PARAMETERS
//   W      16   operand/result width (>=4)
// PORTS
//   clk          in   1   system clock, all logic on rising edge
//   rst          in   1   synchronous, active-high reset
//   start        in   1   request; accepted only when busy=0
//   opcode       in   4   operation select, sampled on accept
//   arg1         in   W   operand 1, sampled on accept
//   arg2         in   W   operand 2, sampled on accept
//   in_flg       in   5   current flags {Z,CY,S,P,OV}, sampled on accept
//   block_cy_ov  in   1   1: ignore carry-in; pass CY/OV through from in_flg
//   busy         out  1   multi-cycle op in progress
//   done         out  1   one-cycle pulse; res/res_hi/out_flg valid
//   res          out  W   result (low half of product, quotient)
//   res_hi       out  W   high half of product / remainder, else 0
//   out_flg      out  5   new flags {Z,CY,S,P,OV}
//   div_zero     out  1   set with done when DIV had arg2=0, else 0
// BEHAVIOUR
//   Reset: state IDLE, busy=0, done=0, res=0, res_hi=0, out_flg=0, div_zero=0.
//     Reset mid-operation aborts it with no done pulse.
//   Accept: start=1 while busy=0 at edge k; operands, opcode and flags are latched.
//   Opcodes: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 NOT arg1, 6 PASS arg1,
//     7 PASS arg2, 8 SHL1 arg1, 9 SHR1 arg1 (logical), 10 SAR1 arg1,
//     12 MUL (unsigned), 13 DIV (unsigned), 11/14/15 behave as PASS arg2.
//   Single-cycle ops (all but MUL/DIV, and DIV by 0): done=1 in cycle k+1.
//     busy stays 0, so back-to-back starts give 1 result per cycle.
//   MUL/DIV: FSM IDLE->RUN on accept. A W-step counter runs shift-add (MUL) or
//     restoring division (DIV).
//     busy=1 in cycles k+1..k+W; RUN->IDLE with done=1, busy=0 in cycle k+W+1.
//     start while busy=1 is ignored, not queued.
//     start is accepted in the done cycle itself.
//   Outputs hold their values between done pulses; done is high for one cycle only.
//   ADD: {CY,res} = arg1+arg2+(CY_in & ~block_cy_ov).
//   SUB: res = arg1-arg2-(CY_in & ~block_cy_ov); CY=borrow.
//   OV(ADD) = a[W-1]==b[W-1] && r[W-1]!=a[W-1].
//   OV(SUB) = a[W-1]!=b[W-1] && r[W-1]!=a[W-1].
//   Logic ops and NOT: CY=0, OV=0. PASS ops: CY=CY_in, OV=OV_in.
//   Shifts: CY = bit shifted out, OV=0; SAR replicates the MSB.
//   MUL: {res_hi,res} = arg1*arg2 (2W bits); CY=OV=(res_hi!=0).
//   DIV: res=arg1/arg2, res_hi=arg1%arg2, CY=0, OV=0.
//     DIV by 0: single-cycle, res=all ones, res_hi=arg1, div_zero=1, OV=1.
//   Z = ~|res. S = res[W-1]. P = ^res (1 = odd number of ones).
//     res_hi is excluded from Z, S and P.
//   block_cy_ov=1: out CY=CY_in and OV=OV_in for every opcode; Z/S/P computed.
// TESTING (W=16)
//   ADD 0x7FFF+0x0001, CY_in=0 -> cycle k+1: done=1, res=0x8000, Z0 CY0 S1 P1 OV1.
//   ADD 0xFFFF+0x0000, CY_in=1, block=0 -> res=0x0000, Z1 CY1.
//     Same with block=1, in_flg CY=1 OV=0 -> res=0xFFFF, CY1 OV0.
//   SUB 0x8000-0x0001 -> res 0x7FFF, OV1 CY0.
//     SUB 0x0000-0x0001 -> res 0xFFFF, CY1 S1.
//   MUL 0x1234*0x0100 -> busy k+1..k+16, done k+17, res=0x3400, res_hi=0x0012,
//     CY1 OV1. A start at k+5 is ignored.
//     A start in cycle k+17 is accepted.
//   DIV 1000/7 -> done k+17, res=0x008E, res_hi=0x0006.
//     DIV 5/0 -> done k+1, res=0xFFFF, res_hi=0x0005, div_zero=1.
//   rst=1 at k+5 of a MUL -> next cycle: busy=0, all outputs 0, no done pulse.
//     A start after rst drops completes normally.

Source files
------------

// File: rtl/alu_seq_if.sv
// Operand/result bundle between the register-file read ports, alu_seq and
// the write-back/flag register. The master drives requests and the slave (the ALU) answers.
interface alu_seq_if #(
  parameter int W = 16
);
  logic         start;
  logic [3:0]   opcode;
  logic [W-1:0] arg1;
  logic [W-1:0] arg2;
  logic [4:0]   in_flg;
  logic         block_cy_ov;
  logic         busy;
  logic         done;
  logic [W-1:0] res;
  logic [W-1:0] res_hi;
  logic [4:0]   out_flg;
  logic         div_zero;

  modport master (
    output start, opcode, arg1, arg2, in_flg, block_cy_ov,
    input  busy, done, res, res_hi, out_flg, div_zero
  );

  modport slave (
    input  start, opcode, arg1, arg2, in_flg, block_cy_ov,
    output busy, done, res, res_hi, out_flg, div_zero
  );
endinterface

// File: rtl/alu_seq.sv
// Registered ALU with flag bus {Z,CY,S,P,OV}: single-cycle logic/arith/shift ops
// plus W-step shift-add multiply and restoring divide behind start/busy/done.
module alu_seq #(
  parameter int W = 16
) (
  input  logic      clk,
  input  logic      rst,
  alu_seq_if.slave  bus
);

  localparam int CW = $clog2(W);

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_PAS1 = 4'd6;
  localparam logic [3:0] OP_PAS2 = 4'd7;
  localparam logic [3:0] OP_SHL1 = 4'd8;
  localparam logic [3:0] OP_SHR1 = 4'd9;
  localparam logic [3:0] OP_SAR1 = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd12;
  localparam logic [3:0] OP_DIV  = 4'd13;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t         state_r;
  state_t         next_state_s;
  logic [CW-1:0]  cnt_r;

  // Multi-cycle working set: a_r is multiplicand or divisor, {hi_r,lo_r} the
  // product shifter or {remainder, quotient/dividend} pair.
  logic [W-1:0]   a_r;
  logic [W-1:0]   hi_r;
  logic [W-1:0]   lo_r;
  logic           mul_r;
  logic           blk_r;
  logic           cy_in_r;
  logic           ov_in_r;

  logic           busy_r;
  logic           done_r;
  logic           dz_r;
  logic [W-1:0]   res_r;
  logic [W-1:0]   res_hi_r;
  logic [4:0]     flg_r;

  logic           accept_s;
  logic           step_s;
  logic           last_s;
  logic           multi_s;

  logic           cin_s;
  logic [W:0]     sum_s;
  logic [W:0]     diff_s;
  logic [W-1:0]   sc_res_s;
  logic [W-1:0]   sc_hi_s;
  logic           sc_cy_raw_s;
  logic           sc_ov_raw_s;
  logic           sc_cy_s;
  logic           sc_ov_s;
  logic           sc_dz_s;

  logic [W:0]     mul_sum_s;
  logic [W:0]     div_sh_s;
  logic [W:0]     div_diff_s;
  logic [W-1:0]   nxt_hi_s;
  logic [W-1:0]   nxt_lo_s;
  logic           fin_cy_s;
  logic           fin_ov_s;

  logic           unused_s;

  function automatic logic parity_odd(input logic [W-1:0] v);
    return ^v;
  endfunction

  function automatic logic [4:0] make_flags(input logic [W-1:0] r, input logic cy,
                                            input logic ov);
    return {~|r, cy, r[W-1], parity_odd(r), ov};
  endfunction

  // Z, S and P of the incoming flags are always recomputed, never passed through.
  assign unused_s = ^{bus.in_flg[4], bus.in_flg[2:1]};

  assign multi_s = (bus.opcode == OP_MUL) ||
                   ((bus.opcode == OP_DIV) && (bus.arg2 != {W{1'b0}}));

  // State register; busy is registered from the next state so it tracks RUN exactly.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == S_RUN);
    end
  end

  // Next-state logic: only MUL and non-zero DIV enter RUN.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (bus.start && multi_s) begin
          next_state_s = S_RUN;
        end else begin
          next_state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (cnt_r == CW'(W - 1)) begin
          next_state_s = S_IDLE;
        end else begin
          next_state_s = S_RUN;
        end
      end
      default: next_state_s = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state.
  always_comb begin
    accept_s = (state_r == S_IDLE) && bus.start;
    step_s   = (state_r == S_RUN);
    last_s   = (state_r == S_RUN) && (cnt_r == CW'(W - 1));
  end

  // Single-cycle result path, evaluated directly on the request inputs.
  always_comb begin
    cin_s       = bus.in_flg[3] & ~bus.block_cy_ov;
    sum_s       = {1'b0, bus.arg1} + {1'b0, bus.arg2} + {{W{1'b0}}, cin_s};
    diff_s      = {1'b0, bus.arg1} - {1'b0, bus.arg2} - {{W{1'b0}}, cin_s};
    sc_res_s    = bus.arg2;
    sc_hi_s     = {W{1'b0}};
    sc_cy_raw_s = bus.in_flg[3];
    sc_ov_raw_s = bus.in_flg[0];
    sc_dz_s     = 1'b0;
    case (bus.opcode)
      OP_ADD: begin
        sc_res_s    = sum_s[W-1:0];
        sc_cy_raw_s = sum_s[W];
        sc_ov_raw_s = (bus.arg1[W-1] == bus.arg2[W-1]) && (sum_s[W-1] != bus.arg1[W-1]);
      end
      OP_SUB: begin
        sc_res_s    = diff_s[W-1:0];
        sc_cy_raw_s = diff_s[W];
        sc_ov_raw_s = (bus.arg1[W-1] != bus.arg2[W-1]) && (diff_s[W-1] != bus.arg1[W-1]);
      end
      OP_AND: begin
        sc_res_s    = bus.arg1 & bus.arg2;
        sc_cy_raw_s = 1'b0;
        sc_ov_raw_s = 1'b0;
      end
      OP_OR: begin
        sc_res_s    = bus.arg1 | bus.arg2;
        sc_cy_raw_s = 1'b0;
        sc_ov_raw_s = 1'b0;
      end
      OP_XOR: begin
        sc_res_s    = bus.arg1 ^ bus.arg2;
        sc_cy_raw_s = 1'b0;
        sc_ov_raw_s = 1'b0;
      end
      OP_NOT: begin
        sc_res_s    = ~bus.arg1;
        sc_cy_raw_s = 1'b0;
        sc_ov_raw_s = 1'b0;
      end
      OP_PAS1: sc_res_s = bus.arg1;
      OP_PAS2: sc_res_s = bus.arg2;
      OP_SHL1: begin
        sc_res_s    = {bus.arg1[W-2:0], 1'b0};
        sc_cy_raw_s = bus.arg1[W-1];
        sc_ov_raw_s = 1'b0;
      end
      OP_SHR1: begin
        sc_res_s    = {1'b0, bus.arg1[W-1:1]};
        sc_cy_raw_s = bus.arg1[0];
        sc_ov_raw_s = 1'b0;
      end
      OP_SAR1: begin
        sc_res_s    = {bus.arg1[W-1], bus.arg1[W-1:1]};
        sc_cy_raw_s = bus.arg1[0];
        sc_ov_raw_s = 1'b0;
      end
      OP_DIV: begin
        // Only reaches this path when the divisor is zero.
        sc_res_s    = {W{1'b1}};
        sc_hi_s     = bus.arg1;
        sc_dz_s     = 1'b1;
        sc_cy_raw_s = 1'b0;
        sc_ov_raw_s = 1'b1;
      end
      default: sc_res_s = bus.arg2;
    endcase
  end

  assign sc_cy_s = bus.block_cy_ov ? bus.in_flg[3] : sc_cy_raw_s;
  assign sc_ov_s = bus.block_cy_ov ? bus.in_flg[0] : sc_ov_raw_s;

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum_s  = {1'b0, hi_r} + (lo_r[0] ? {1'b0, a_r} : {(W+1){1'b0}});
    div_sh_s   = {hi_r, lo_r[W-1]};
    div_diff_s = div_sh_s - {1'b0, a_r};
    if (mul_r) begin
      nxt_hi_s = mul_sum_s[W:1];
      nxt_lo_s = {mul_sum_s[0], lo_r[W-1:1]};
    end else if (!div_diff_s[W]) begin
      nxt_hi_s = div_diff_s[W-1:0];
      nxt_lo_s = {lo_r[W-2:0], 1'b1};
    end else begin
      nxt_hi_s = div_sh_s[W-1:0];
      nxt_lo_s = {lo_r[W-2:0], 1'b0};
    end
  end

  assign fin_cy_s = blk_r ? cy_in_r : (mul_r & (|nxt_hi_s));
  assign fin_ov_s = blk_r ? ov_in_r : (mul_r & (|nxt_hi_s));

  // Datapath and output registers; outputs hold between done pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r    <= {CW{1'b0}};
      a_r      <= {W{1'b0}};
      hi_r     <= {W{1'b0}};
      lo_r     <= {W{1'b0}};
      mul_r    <= 1'b0;
      blk_r    <= 1'b0;
      cy_in_r  <= 1'b0;
      ov_in_r  <= 1'b0;
      done_r   <= 1'b0;
      dz_r     <= 1'b0;
      res_r    <= {W{1'b0}};
      res_hi_r <= {W{1'b0}};
      flg_r    <= 5'b00000;
    end else begin
      done_r <= 1'b0;
      if (accept_s && !multi_s) begin
        res_r    <= sc_res_s;
        res_hi_r <= sc_hi_s;
        flg_r    <= make_flags(sc_res_s, sc_cy_s, sc_ov_s);
        dz_r     <= sc_dz_s;
        done_r   <= 1'b1;
      end else if (accept_s) begin
        mul_r   <= (bus.opcode == OP_MUL);
        a_r     <= (bus.opcode == OP_MUL) ? bus.arg1 : bus.arg2;
        lo_r    <= (bus.opcode == OP_MUL) ? bus.arg2 : bus.arg1;
        hi_r    <= {W{1'b0}};
        blk_r   <= bus.block_cy_ov;
        cy_in_r <= bus.in_flg[3];
        ov_in_r <= bus.in_flg[0];
        cnt_r   <= {CW{1'b0}};
      end else if (step_s) begin
        hi_r  <= nxt_hi_s;
        lo_r  <= nxt_lo_s;
        cnt_r <= cnt_r + CW'(1);
        if (last_s) begin
          res_r    <= nxt_lo_s;
          res_hi_r <= nxt_hi_s;
          flg_r    <= make_flags(nxt_lo_s, fin_cy_s, fin_ov_s);
          dz_r     <= 1'b0;
          done_r   <= 1'b1;
        end
      end
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.res      = res_r;
  assign bus.res_hi   = res_hi_r;
  assign bus.out_flg  = flg_r;
  assign bus.div_zero = dz_r;

endmodule
